// File: rtl/ysyx_22040759_mdu_pkg.sv
// ============================================================================
// Module      : ysyx_22040759_mdu_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               RV64M operation encodings, FSM state encoding, the decoded
//               per-operation control word and the opcode decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_22040759_mdu_pkg;

    // Operation encodings (13..15 are reserved and execute as MUL)
    localparam logic [3:0] MDU_MUL    = 4'd0;
    localparam logic [3:0] MDU_MULH   = 4'd1;
    localparam logic [3:0] MDU_MULHSU = 4'd2;
    localparam logic [3:0] MDU_MULHU  = 4'd3;
    localparam logic [3:0] MDU_DIV    = 4'd4;
    localparam logic [3:0] MDU_DIVU   = 4'd5;
    localparam logic [3:0] MDU_REM    = 4'd6;
    localparam logic [3:0] MDU_REMU   = 4'd7;
    localparam logic [3:0] MDU_MULW   = 4'd8;
    localparam logic [3:0] MDU_DIVW   = 4'd9;
    localparam logic [3:0] MDU_DIVUW  = 4'd10;
    localparam logic [3:0] MDU_REMW   = 4'd11;
    localparam logic [3:0] MDU_REMUW  = 4'd12;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    // Decoded view of one operation
    typedef struct packed {
        logic is_div;   // divide class (DIV*/REM*)
        logic is_rem;   // return remainder instead of quotient
        logic is_word;  // 32-bit operation, result sign-extended
        logic is_high;  // return upper half of the product
        logic sgn1;     // src1 treated as signed
        logic sgn2;     // src2 treated as signed
    } mdu_ctrl_t;

    function automatic mdu_ctrl_t mdu_decode(input logic [3:0] op);
        mdu_ctrl_t c;
        c = '0;
        case (op)
            MDU_MULH:   begin c.is_high = 1'b1; c.sgn1 = 1'b1; c.sgn2 = 1'b1; end
            MDU_MULHSU: begin c.is_high = 1'b1; c.sgn1 = 1'b1; end
            MDU_MULHU:  begin c.is_high = 1'b1; end
            MDU_DIV:    begin c.is_div = 1'b1; c.sgn1 = 1'b1; c.sgn2 = 1'b1; end
            MDU_DIVU:   begin c.is_div = 1'b1; end
            MDU_REM:    begin c.is_div = 1'b1; c.is_rem = 1'b1; c.sgn1 = 1'b1; c.sgn2 = 1'b1; end
            MDU_REMU:   begin c.is_div = 1'b1; c.is_rem = 1'b1; end
            MDU_MULW:   begin c.is_word = 1'b1; end
            MDU_DIVW:   begin c.is_div = 1'b1; c.is_word = 1'b1; c.sgn1 = 1'b1; c.sgn2 = 1'b1; end
            MDU_DIVUW:  begin c.is_div = 1'b1; c.is_word = 1'b1; end
            MDU_REMW:   begin c.is_div = 1'b1; c.is_rem = 1'b1; c.is_word = 1'b1;
                              c.sgn1 = 1'b1; c.sgn2 = 1'b1; end
            MDU_REMUW:  begin c.is_div = 1'b1; c.is_rem = 1'b1; c.is_word = 1'b1; end
            default:    ; // MUL and reserved: unsigned low-half multiply
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040759_mdu_step.sv
// ============================================================================
// Module      : ysyx_22040759_mdu_step
// Description : One combinational iteration of the multiply/divide datapath.
//               Multiply: conditional add of opd into the upper half, then
//               shift the accumulator right by one.
//               Divide: restoring trial subtract of opd from the shifted
//               partial remainder; quotient bit enters at bit 0.
// Ports       : is_div  - select divide iteration (else multiply)
//               acc_in  - current 2*XLEN accumulator
//               opd     - multiplicand / divisor magnitude
//               acc_out - accumulator after this iteration
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040759_mdu_step #(
    parameter int XLEN = 64
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   opd,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] trial;
    logic          qbit;

    always_comb begin
        // Carry out of the add lands in the top bit after the right shift.
        add_sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opd} : '0);
        rem_shift = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
        trial     = rem_shift - {1'b0, opd};
        // Remainder < divisor keeps rem_shift < 2*divisor, so bit XLEN of the
        // difference is a clean borrow flag.
        qbit      = ~trial[XLEN];
        if (is_div) begin
            acc_out = {(qbit ? trial[XLEN-1:0] : rem_shift[XLEN-1:0]),
                       acc_in[XLEN-2:0], qbit};
        end else begin
            acc_out = {add_sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_22040759_mdu.sv
// ============================================================================
// Module      : ysyx_22040759_mdu
// Description : Iterative RV64M multiply/divide unit. Operands are turned
//               into unsigned magnitudes, iterated one bit per cycle, then
//               sign-corrected. Divide-by-zero and signed overflow skip the
//               iteration.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready/in_op/in_src1/in_src2 - request handshake
//               flush (only with YSYX_22040759_MDU_FLUSH_EN) - abort
//               out_valid/out_ready/out_result          - result handshake
// Config      : YSYX_22040759_MDU_FLUSH_EN adds the flush port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040759_mdu
    import ysyx_22040759_mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
`ifdef YSYX_22040759_MDU_FLUSH_EN
    input  logic            flush,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam int               CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_XLEN = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(31);
    localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  WMIN     = {{(XLEN-31){1'b1}}, 31'b0};

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    mdu_ctrl_t         ctrl_q, ctrl_d;
    logic              neg_p_q, neg_p_d;     // negate product / quotient
    logic              neg_r_q, neg_r_d;     // negate remainder
    logic              special_q, special_d; // result already in acc low half
    logic [XLEN-1:0]   out_result_q, out_result_d;

    logic abort;
`ifdef YSYX_22040759_MDU_FLUSH_EN
    assign abort = flush;
`else
    assign abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Operand preparation for the request at the input
    // ------------------------------------------------------------------
    mdu_ctrl_t       ctrl_in;
    logic [XLEN-1:0] src1_x, src2_x, src1_sx;
    logic [XLEN-1:0] mag1, mag2, div_lo, spec_res;
    logic            neg1, neg2, div_zero, div_ovf, accept;

    always_comb begin
        ctrl_in = mdu_decode(in_op);
        if (ctrl_in.is_word) begin
            src1_x = {{(XLEN-32){ctrl_in.sgn1 & in_src1[31]}}, in_src1[31:0]};
            src2_x = {{(XLEN-32){ctrl_in.sgn2 & in_src2[31]}}, in_src2[31:0]};
        end else begin
            src1_x = in_src1;
            src2_x = in_src2;
        end
        // Dividend as returned by the special cases: word results are
        // always sign-extended from bit 31, even for unsigned ops.
        src1_sx  = ctrl_in.is_word ? {{(XLEN-32){in_src1[31]}}, in_src1[31:0]} : in_src1;
        neg1     = ctrl_in.sgn1 & src1_x[XLEN-1];
        neg2     = ctrl_in.sgn2 & src2_x[XLEN-1];
        mag1     = neg1 ? -src1_x : src1_x;
        mag2     = neg2 ? -src2_x : src2_x;
        // A word dividend is pre-shifted so its MSB is consumed first and
        // 32 iterations leave the quotient in the low 32 bits.
        div_lo   = ctrl_in.is_word ? (mag1 << (XLEN - 32)) : mag1;
        div_zero = ctrl_in.is_div & (src2_x == '0);
        div_ovf  = ctrl_in.is_div & ctrl_in.sgn1 & (src2_x == '1) &
                   (src1_x == (ctrl_in.is_word ? WMIN : XMIN));
        if (div_zero) begin
            spec_res = ctrl_in.is_rem ? src1_sx : '1;
        end else begin
            spec_res = ctrl_in.is_rem ? '0 : src1_sx;
        end
        accept   = in_valid & (state_q == MDU_IDLE) & ~abort;
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] acc_step;

    ysyx_22040759_mdu_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div  (ctrl_q.is_div),
        .acc_in  (acc_q),
        .opd     (opd_q),
        .acc_out (acc_step)
    );

    // ------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, pick, fix_res;

    always_comb begin
        // A word product finishes 32 bits above its natural position.
        prod = ctrl_q.is_word ? (acc_q >> (XLEN - 32)) : acc_q;
        if (neg_p_q) begin
            prod = -prod;
        end
        quo = neg_p_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem = neg_r_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (ctrl_q.is_div) begin
            pick = ctrl_q.is_rem ? rem : quo;
        end else begin
            pick = ctrl_q.is_high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
        if (special_q) begin
            fix_res = acc_q[XLEN-1:0];
        end else if (ctrl_q.is_word) begin
            fix_res = {{(XLEN-32){pick[31]}}, pick[31:0]};
        end else begin
            fix_res = pick;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        opd_d        = opd_q;
        ctrl_d       = ctrl_q;
        neg_p_d      = neg_p_q;
        neg_r_d      = neg_r_q;
        special_d    = special_q;
        out_result_d = out_result_q;

        case (state_q)
            MDU_IDLE: begin
                if (accept) begin
                    ctrl_d  = ctrl_in;
                    neg_p_d = neg1 ^ neg2;
                    neg_r_d = neg1;
                    if (div_zero || div_ovf) begin
                        // Resolved now; FIX only publishes it.
                        special_d = 1'b1;
                        acc_d     = {{XLEN{1'b0}}, spec_res};
                        state_d   = MDU_FIX;
                    end else begin
                        special_d = 1'b0;
                        acc_d     = {{XLEN{1'b0}}, (ctrl_in.is_div ? div_lo : mag2)};
                        opd_d     = ctrl_in.is_div ? mag2 : mag1;
                        cnt_d     = ctrl_in.is_word ? CNT_WORD : CNT_XLEN;
                        state_d   = MDU_BUSY;
                    end
                end
            end
            MDU_BUSY: begin
                acc_d = acc_step;
                if (cnt_q == '0) begin
                    state_d = MDU_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MDU_FIX: begin
                out_result_d = fix_res;
                state_d      = MDU_DONE;
            end
            MDU_DONE: begin
                if (out_ready) begin
                    state_d = MDU_IDLE;
                end
            end
            default: state_d = MDU_IDLE;
        endcase

        if (abort) begin
            state_d = MDU_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= MDU_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            opd_q        <= '0;
            ctrl_q       <= '0;
            neg_p_q      <= 1'b0;
            neg_r_q      <= 1'b0;
            special_q    <= 1'b0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            opd_q        <= opd_d;
            ctrl_q       <= ctrl_d;
            neg_p_q      <= neg_p_d;
            neg_r_q      <= neg_r_d;
            special_q    <= special_d;
            out_result_q <= out_result_d;
        end
    end

    assign in_ready   = (state_q == MDU_IDLE);
    assign out_valid  = (state_q == MDU_DONE);
    assign out_result = out_result_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040759_mdu.sv
// ============================================================================
// Module      : tb_ysyx_22040759_mdu
// Description : Self-checking bench for ysyx_22040759_mdu (XLEN=64) with a
//               plain-arithmetic reference model. Flush scenario is built
//               only when YSYX_22040759_MDU_FLUSH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22040759_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    ysyx_22040759_mdu #(
        .XLEN (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
`ifdef YSYX_22040759_MDU_FLUSH_EN
        .flush      (flush),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa, sb;
        logic signed [31:0] wa, wb;
        logic [31:0]        ua, ub;
        logic               ovf64, ovf32;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        ovf32 = (ua == 32'h8000_0000) && (ub == 32'hFFFF_FFFF);
        case (op)
            4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
            4'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
            4'd4: begin
                if (b == 0) return '1;
                if (ovf64) return a;
                return sa / sb;
            end
            4'd5: begin if (b == 0) return '1; return a / b; end
            4'd6: begin
                if (b == 0) return a;
                if (ovf64) return 64'd0;
                return sa % sb;
            end
            4'd7: begin if (b == 0) return a; return a % b; end
            4'd8: return sx32(ua * ub);
            4'd9: begin
                if (ub == 0) return '1;
                if (ovf32) return sx32(ua);
                return sx32(wa / wb);
            end
            4'd10: begin if (ub == 0) return '1; return sx32(ua / ub); end
            4'd11: begin
                if (ub == 0) return sx32(ua);
                if (ovf32) return 64'd0;
                return sx32(wa % wb);
            end
            4'd12: begin if (ub == 0) return sx32(ua); return sx32(ua % ub); end
            default: return a * b;
        endcase
    endfunction

    // Edges from accept until out_valid is seen.
    function automatic int model_lat(input logic [3:0] op, input logic [63:0] a,
                                     input logic [63:0] b);
        bit is_div, is_word, is_sgn, special;
        is_div  = (op >= 4'd4 && op <= 4'd7) || (op >= 4'd9 && op <= 4'd12);
        is_word = (op >= 4'd8 && op <= 4'd12);
        is_sgn  = (op == 4'd4) || (op == 4'd6) || (op == 4'd9) || (op == 4'd11);
        special = 1'b0;
        if (is_div) begin
            if (is_word) begin
                special = (b[31:0] == 0) ||
                          (is_sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
            end else begin
                special = (b == 0) ||
                          (is_sgn && a == 64'h8000_0000_0000_0000 && b == '1);
            end
        end
        if (special) return 1;
        if (is_word) return 33;
        return 65;
    endfunction

    // ---------------- driver (no checking) ----------------
    // Entered #1 after an edge with the DUT idle; returns #1 after the
    // handoff edge, or right after out_valid is seen if out_ready is low.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat);
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
        end
        res = out_result;
        if (out_ready && out_valid) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 64'd0)
            $display("FAIL reset_hold: ready=%b valid=%b result=%h, want 1 0 0",
                     in_ready, out_valid, out_result);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 64'd0)
            $display("FAIL reset_after: ready=%b valid=%b result=%h, want 1 0 0",
                     in_ready, out_valid, out_result);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [3:0]  ops  [12] = '{4'd0, 4'd3, 4'd2, 4'd4, 4'd6, 4'd5, 4'd7, 4'd4,
                                   4'd9, 4'd12, 4'd8, 4'd15};
        logic [63:0] as   [12] = '{64'd7, '1, '1, -64'sd7, -64'sd7, 64'd5, 64'd5,
                                   64'h8000_0000_0000_0000, 64'h8000_0000,
                                   64'h1_0000_0007, 64'h7FFF_FFFF, 64'd3};
        logic [63:0] bs   [12] = '{-64'sd3, '1, 64'd2, 64'd2, 64'd2, 64'd0, 64'd0,
                                   '1, 64'hFFFF_FFFF, 64'd2, 64'd2, 64'd5};
        logic [63:0] exps [12] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE,
                                   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD,
                                   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                   64'd5, 64'h8000_0000_0000_0000,
                                   64'hFFFF_FFFF_8000_0000, 64'd1,
                                   64'hFFFF_FFFF_FFFF_FFFE, 64'd15};
        int          lats [12] = '{65, 65, 65, 65, 65, 1, 1, 1, 1, 33, 33, 65};
        logic [63:0] res;
        int          lat;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat);
            chk_cnt++;
            if (res !== exps[i])
                $display("FAIL directed_%0d_result: op=%0d got %h want %h", i, ops[i], res, exps[i]);
            else pass_cnt++;
            chk_cnt++;
            if (lat != lats[i])
                $display("FAIL directed_%0d_latency: op=%0d got %0d want %0d", i, ops[i], lat, lats[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [63:0] a, b, res, exp;
        int          lat, sel;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 64'd0;
            if (sel == 1) begin a = 64'h8000_0000_0000_0000; b = '1; end
            if (sel == 2) begin a = {$urandom, 32'h8000_0000}; b = '1; end
            if (sel == 3) b = 64'($urandom_range(1, 15));
            exp = model(op, a, b);
            run_op(op, a, b, res, lat);
            chk_cnt++;
            if (res !== exp)
                $display("FAIL random_%0d_result: op=%0d a=%h b=%h got %h want %h",
                         i, op, a, b, res, exp);
            else pass_cnt++;
            chk_cnt++;
            if (lat != model_lat(op, a, b))
                $display("FAIL random_%0d_latency: op=%0d got %0d want %0d",
                         i, op, lat, model_lat(op, a, b));
            else pass_cnt++;
        end
    endtask

    // Result held under backpressure, then a request presented during the
    // handoff edge must wait for the following edge.
    task automatic test_backpressure();
        logic [63:0] a, b, res, res2;
        int          lat, lat2;
        a = {$urandom, $urandom};
        b = 64'($urandom_range(3, 100000));
        out_ready = 1'b0;
        run_op(4'd5, a, b, res, lat);
        chk_cnt++;
        if (res !== a / b || lat != 65)
            $display("FAIL hold_result: got %h lat %0d want %h lat 65", res, lat, a / b);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== res)
                $display("FAIL hold_cycle_%0d: valid=%b ready=%b result=%h want 1 0 %h",
                         i, out_valid, in_ready, out_result, res);
            else pass_cnt++;
        end
        in_op     = 4'd11;
        in_src1   = 64'hFFFF_FFF9;
        in_src2   = 64'd4;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL handoff_no_accept: valid=%b ready=%b want 0 1", out_valid, in_ready);
        else pass_cnt++;
        run_op(4'd11, 64'hFFFF_FFF9, 64'd4, res2, lat2);
        chk_cnt++;
        if (res2 !== 64'hFFFF_FFFF_FFFF_FFFD || lat2 != 33)
            $display("FAIL handoff_next_op: got %h lat %0d want fffffffffffffffd lat 33", res2, lat2);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int          lat;
        out_ready = 1'b1;
        run_op(4'd1, 64'h8000_0000_0000_0000, 64'd2, res, lat);
        chk_cnt++;
        if (res !== '1 || in_ready !== 1'b1)
            $display("FAIL b2b_first: got %h ready %b want ffffffffffffffff ready 1", res, in_ready);
        else pass_cnt++;
        run_op(4'd10, 64'hABCD_0000_0000_0064, 64'd7, res, lat);
        chk_cnt++;
        if (res !== 64'd14 || lat != 33)
            $display("FAIL b2b_second: got %h lat %0d want e lat 33", res, lat);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int          lat;
        in_op    = 4'd4;
        in_src1  = 64'd1000;
        in_src2  = 64'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 64'd0)
            $display("FAIL reset_mid: ready=%b valid=%b result=%h want 1 0 0",
                     in_ready, out_valid, out_result);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(4'd0, 64'd123, 64'd456, res, lat);
        chk_cnt++;
        if (res !== 64'd56088 || lat != 65)
            $display("FAIL reset_mid_recover: got %h lat %0d want db18 lat 65", res, lat);
        else pass_cnt++;
    endtask

`ifdef YSYX_22040759_MDU_FLUSH_EN
    task automatic test_flush();
        logic [63:0] res;
        int          lat;
        bit          seen;
        in_op    = 4'd4;
        in_src1  = {$urandom, $urandom};
        in_src2  = 64'($urandom_range(2, 1000));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 4'd0;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL flush_idle: ready=%b valid=%b want 1 0", in_ready, out_valid);
        else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        chk_cnt++;
        if (seen !== 1'b0)
            $display("FAIL flush_quiet: activity after flush=%b want 0", seen);
        else pass_cnt++;
        run_op(4'd7, 64'd100, 64'd7, res, lat);
        chk_cnt++;
        if (res !== 64'd2 || lat != 65)
            $display("FAIL flush_recover: got %h lat %0d want 2 lat 65", res, lat);
        else pass_cnt++;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_src1   = 64'd0;
        in_src2   = 64'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef YSYX_22040759_MDU_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
